// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: control strobes and memory fill port in, fetched word out.
// Master is the control sequencer / boot loader side, slave is the fetch unit.
interface instr_fetch_unit_if #(
   parameter int MEM_DEPTH = 64
);
   localparam int AW = $clog2(MEM_DEPTH);

   logic          I_enpc;
   logic          I_enmem;
   logic          I_ldpc;
   logic [31:0]   I_target;
   logic          I_wen;
   logic [AW-1:0] I_waddr;
   logic [31:0]   I_wdata;
   logic [31:0]   O_pc;
   logic [31:0]   O_instr;
   logic          O_valid;
   logic          O_err;

   modport master (
      output I_enpc, I_enmem, I_ldpc, I_target,
      output I_wen, I_waddr, I_wdata,
      input  O_pc, O_instr, O_valid, O_err
   );

   modport slave (
      input  I_enpc, I_enmem, I_ldpc, I_target,
      input  I_wen, I_waddr, I_wdata,
      output O_pc, O_instr, O_valid, O_err
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, instruction memory and registered fetch output.
// Define FETCH_PROTO_CHECK_EN to build the sticky strobe-protocol error flag.
module instr_fetch_unit #(
   parameter int          XLEN      = 32,
   parameter int          MEM_DEPTH = 64,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input  logic                    clk,
   input  logic                    I_reset,
   instr_fetch_unit_if.slave       bus
);
   localparam int AW = $clog2(MEM_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PC_RDY,
      S_FETCH
   } state_t;

   state_t          state;
   logic            first_pc;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] instr;
   logic            valid;
   logic [XLEN-1:0] mem [MEM_DEPTH];
   logic [AW-1:0]   rd_idx;

   // upper PC bits alias onto the memory
   assign rd_idx = pc[2 +: AW];

   always_ff @(posedge clk) begin
      if (I_reset && bus.I_wen)
         mem[bus.I_waddr] <= bus.I_wdata;
   end

   always_ff @(posedge clk) begin
      if (!I_reset) begin
         state    <= S_IDLE;
         first_pc <= 1'b1;
         pc       <= RESET_PC;
         instr    <= '0;
         valid    <= 1'b0;
      end else if (bus.I_enpc) begin
         // the first strobe after reset fetches RESET_PC itself
         if (!first_pc)
            pc <= bus.I_ldpc ? (bus.I_target & ~XLEN'(3))
                             : pc + XLEN'(4);
         first_pc <= 1'b0;
         valid    <= 1'b0;
         state    <= S_PC_RDY;
      end else if (bus.I_enmem && state == S_PC_RDY) begin
         instr <= mem[rd_idx];
         valid <= 1'b1;
         state <= S_FETCH;
      end
   end

   assign bus.O_pc    = pc;
   assign bus.O_instr = instr;
   assign bus.O_valid = valid;

`ifdef FETCH_PROTO_CHECK_EN
   logic err;
   logic viol;

   always_comb begin
      viol = 1'b0;
      if (bus.I_enpc)
         viol = bus.I_enmem || (state == S_PC_RDY);
      else if (bus.I_enmem)
         viol = (state != S_PC_RDY);
   end

   always_ff @(posedge clk) begin
      if (!I_reset)
         err <= 1'b0;
      else if (viol)
         err <= 1'b1;
   end

   assign bus.O_err = err;
`else
   assign bus.O_err = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed fetch sequences plus
// randomized strobes checked against a behavioural fetch model.
module tb_instr_fetch_unit;
   localparam int          MEM_DEPTH = 64;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;

   logic clk = 1'b0;
   logic I_reset;

   always #5 clk = ~clk;

   instr_fetch_unit_if #(.MEM_DEPTH(MEM_DEPTH)) bus ();

   instr_fetch_unit #(
      .XLEN      (32),
      .MEM_DEPTH (MEM_DEPTH),
      .RESET_PC  (RESET_PC)
   ) dut (
      .clk     (clk),
      .I_reset (I_reset),
      .bus     (bus)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
      logic        err;
      int          id;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   step_id = 0;

   // behavioural model
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic        m_valid;
   logic        m_err;
   bit          m_first;
   bit          m_wait;
   logic [31:0] m_mem [MEM_DEPTH];

   task automatic chk(input string name, input int id,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %08h expected %08h",
                  name, id, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         chk("O_pc",    e.id, bus.O_pc,           e.pc);
         chk("O_instr", e.id, bus.O_instr,        e.instr);
         chk("O_valid", e.id, 32'(bus.O_valid),   32'(e.valid));
         chk("O_err",   e.id, 32'(bus.O_err),     32'(e.err));
      end
   end

   task automatic step(input bit rst, input bit en_pc, input bit en_mem,
                       input bit ld, input logic [31:0] tgt,
                       input bit we, input int wa, input logic [31:0] wd);
      bit          viol;
      logic [31:0] rd;
      exp_t        e;
      I_reset      = ~rst;
      bus.I_enpc   = en_pc;
      bus.I_enmem  = en_mem;
      bus.I_ldpc   = ld;
      bus.I_target = tgt;
      bus.I_wen    = we;
      bus.I_waddr  = 6'(wa);
      bus.I_wdata  = wd;
      @(posedge clk);
      if (rst) begin
         m_pc    = RESET_PC;
         m_instr = 32'h0;
         m_valid = 1'b0;
         m_err   = 1'b0;
         m_first = 1'b1;
         m_wait  = 1'b0;
      end else begin
         viol = 1'b0;
         rd   = m_mem[(m_pc >> 2) % MEM_DEPTH];
         if (en_pc) begin
            viol = en_mem || m_wait;
            if (!m_first)
               m_pc = ld ? {tgt[31:2], 2'b00} : m_pc + 32'd4;
            m_first = 1'b0;
            m_valid = 1'b0;
            m_wait  = 1'b1;
         end else if (en_mem) begin
            if (m_wait) begin
               m_instr = rd;
               m_valid = 1'b1;
               m_wait  = 1'b0;
            end else begin
               viol = 1'b1;
            end
         end
`ifdef FETCH_PROTO_CHECK_EN
         if (viol)
            m_err = 1'b1;
`endif
         if (we)
            m_mem[wa % MEM_DEPTH] = wd;
      end
      e.pc    = m_pc;
      e.instr = m_instr;
      e.valid = m_valid;
      e.err   = m_err;
      e.id    = step_id;
      sbq.push_back(e);
      step_id++;
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
   endtask

   task automatic pc_inc();
      step(0, 1, 0, 0, 32'h0, 0, 0, 32'h0);
   endtask

   task automatic pc_ld(input logic [31:0] t);
      step(0, 1, 0, 1, t, 0, 0, 32'h0);
   endtask

   task automatic fetch();
      step(0, 0, 1, 0, 32'h0, 0, 0, 32'h0);
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      step(0, 0, 0, 0, 32'h0, 1, a, d);
   endtask

   initial begin
      I_reset      = 1'b0;
      bus.I_enpc   = 1'b0;
      bus.I_enmem  = 1'b0;
      bus.I_ldpc   = 1'b0;
      bus.I_target = 32'h0;
      bus.I_wen    = 1'b0;
      bus.I_waddr  = '0;
      bus.I_wdata  = 32'h0;

      step(1, 0, 0, 0, 32'h0, 0, 0, 32'h0);
      step(1, 1, 1, 1, 32'h40, 0, 0, 32'h0);

      for (int i = 0; i < MEM_DEPTH; i++)
         wr(i, $urandom);
      wr(0, 32'h0000_0013);
      wr(1, 32'h0010_0093);
      wr(2, 32'hAAAA_AAAA);

      // sequential fetches from reset
      pc_inc(); fetch();
      pc_inc(); fetch();
      idle();

      // load with misaligned target, index wraps
      pc_ld(32'h0000_0107); fetch();

      // PC wrap past top of address space
      pc_ld(32'hFFFF_FFFC); fetch();
      pc_inc(); fetch();

      // protocol violations
      fetch();
      step(0, 1, 1, 0, 32'h0, 0, 0, 32'h0);
      pc_inc();
      fetch();

      // reset between PC update and read
      pc_inc();
      step(1, 0, 0, 0, 32'h0, 0, 0, 32'h0);
      fetch();
      pc_inc(); fetch();

      // write-during-read returns old word
      step(1, 0, 0, 0, 32'h0, 0, 0, 32'h0);
      pc_inc(); fetch();
      pc_inc(); fetch();
      pc_inc();
      step(0, 0, 1, 0, 32'h0, 1, 2, 32'hDEAD_BEEF);
      pc_ld(32'h0000_0008); fetch();

      // reset overrides a write
      step(1, 0, 0, 0, 32'h0, 1, 0, 32'h1234_5678);
      pc_inc(); fetch();

      for (int n = 0; n < 3000; n++) begin
         bit          r, p, m, l, w;
         logic [31:0] t;
         r = ($urandom_range(0, 49) == 0);
         p = ($urandom_range(0, 2) == 0);
         m = ($urandom_range(0, 2) == 0);
         l = $urandom_range(0, 1);
         t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
         w = ($urandom_range(0, 7) == 0);
         step(r, p, m, l, t, w, $urandom_range(0, MEM_DEPTH - 1), $urandom);
      end

      idle();
      @(negedge clk);
      #1;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch-stage responder for the processor's control-unit enable sequence. It consumes the program-counter enable and the memory enable strobes issued by the control sequencer, maintains the 32-bit program counter, reads the addressed word from an internal instruction memory, and presents the fetched instruction with a valid flag to the decode stage. A side write port lets the bench or a boot loader fill the instruction memory.

## Interface
- XLEN, 32, datapath/instruction width (fixed at 32; not to be overridden)
- MEM_DEPTH, 64, instruction memory depth in words; power of two, ≥ 2
- RESET_PC, 32'h0000_0000, PC value after reset; word-aligned
- clk  input  1  system clock, all state on rising edge
- I_reset  input  1  synchronous, active-low reset (0 = reset)
- I_enpc  input  1  PC-update strobe from control unit, one cycle wide
- I_enmem  input  1  memory-read strobe from control unit, one cycle wide
- I_ldpc  input  1  qualifies I_enpc: load I_target instead of incrementing
- I_target  input  32  branch/jump target; bits [1:0] ignored
- I_wen  input  1  instruction memory write enable
- I_waddr  input  $clog2(MEM_DEPTH)  word write address
- I_wdata  input  32  word write data
- O_pc  output  32  current program counter (byte address)
- O_instr  output  32  last fetched instruction
- O_valid  output  1  O_instr corresponds to O_pc
- O_err  output  1  sticky protocol-violation flag (see Configuration)

## Operation
- States: S_IDLE (after reset), S_PC_RDY (PC updated, awaiting read), S_FETCH (instruction valid).
- Internal flag first_pc set by reset, cleared by first accepted I_enpc.
- I_enpc in any state: if first_pc, PC keeps RESET_PC; else PC ← I_ldpc ? {I_target[31:2],2'b00} : PC + 4. O_valid ← 0; state → S_PC_RDY.
- I_enmem in S_PC_RDY (and I_enpc low): O_instr ← mem[PC[2 +: $clog2(MEM_DEPTH)]]; O_valid ← 1; state → S_FETCH.
- I_enmem in S_IDLE or S_FETCH: ignored, no state change; violation.
- I_enpc and I_enmem same cycle: I_enpc executes, I_enmem ignored; violation.
- I_enpc while in S_PC_RDY (no intervening read): PC advances again; violation.
- PC + 4 wraps modulo 2^32 (FFFF_FFFC → 0000_0000); memory index wraps modulo MEM_DEPTH (upper PC bits ignored).
- I_wen: mem[I_waddr] ← I_wdata, independent of FSM. Write and read of same word in same cycle: read returns old contents.
- I_ldpc without I_enpc: no effect.

## Timing
- Reset (I_reset = 0 at a rising edge): O_pc = RESET_PC, O_instr = 0, O_valid = 0, O_err = 0, state S_IDLE, first_pc = 1. Memory contents not reset. Reset overrides all simultaneous strobes and writes, including mid-fetch.
- I_enpc sampled at edge k → new O_pc visible after edge k (1-cycle latency).
- I_enmem sampled at edge k → O_instr and O_valid = 1 after edge k; combinational path from memory to O_instr not permitted (registered output).
- Written word readable by I_enmem from the edge after the write.
- All outputs registered; no combinational input-to-output paths.

## Configuration
- FETCH_PROTO_CHECK_EN defined: O_err sets on any violation listed under Operation and stays 1 until reset.
- Not defined: violation detection logic omitted; O_err tied to 0. Functional behaviour of PC/memory identical in both builds.

## Test plan
- Reset, write mem[0]=0000_0013, mem[1]=0010_0093; I_enpc, then I_enmem → O_pc=0000_0000, O_instr=0000_0013, O_valid=1; repeat → O_pc=0000_0004, O_instr=0010_0093, O_err=0.
- I_enpc with I_ldpc=1, I_target=0000_0107, then I_enmem → O_pc=0000_0104, O_instr=mem[65 mod 64]=mem[1].
- After first fetch, load target FFFF_FFFC, fetch, then plain I_enpc → O_pc=0000_0000, fetch returns mem[0].
- Same-cycle I_enpc+I_enmem, and I_enmem in S_FETCH → PC advances once, O_valid=0 then unchanged, O_err=1 (0 with macro undefined).
- I_reset=0 one cycle after I_enpc, before I_enmem → all outputs to reset values, subsequent I_enmem ignored, next I_enpc yields O_pc=RESET_PC.
- I_wen to word 2 with I_wdata=DEAD_BEEF on the same edge as I_enmem reading word 2 (old AAAA_AAAA) → O_instr=AAAA_AAAA; next fetch sequence at that PC → DEAD_BEEF.
